// File: rtl/hid_packet_tx.sv
// hid_packet_tx: UART-side encoder and transmitter for the retro_paint HID link.
// Takes one {cmd, x, y} command per handshake and builds the 3-byte frame
// Header, X, Y from it. The frame is sent 8N1, LSB first, on tx_pin.
// Optionally, GAP_BITS mark bit-times are inserted between the bytes of a frame.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_btn  in   asynchronous active-low reset
//   cmd_in     in   [2:0] command code (1 = move, 2 = draw, others passed through)
//   x_in       in   [5:0] X coordinate
//   y_in       in   [5:0] Y coordinate
//   valid_in   in   send request, sampled only while ready=1
//   ready      out  idle and able to accept a command
//   tx_pin     out  serial line, idle high
//   busy       out  frame in flight (~ready)
//   frame_done out  one-cycle pulse when a frame completes
module hid_packet_tx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned GAP_BITS  = 0
) (
    input  logic       clk,
    input  logic       reset_btn,
    input  logic [2:0] cmd_in,
    input  logic [5:0] x_in,
    input  logic [5:0] y_in,
    input  logic       valid_in,
    output logic       ready,
    output logic       tx_pin,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned GAP_W        = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_BITS);
    localparam logic [1:0]        LAST_IDX  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    // Captured command, held for the whole frame
    typedef struct packed {
        logic [2:0] cmd;
        logic [5:0] x;
        logic [5:0] y;
    } cmd_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [2:0]        bit_q, bit_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [GAP_W-1:0]  gap_inc;
    logic              tail_q, tail_d;
    cmd_t              hold_q, hold_d;
    logic              tx_d;
    logic              ready_d;
    logic              busy_d;
    logic              done_d;

    logic              bit_end;
    logic [7:0]        cur_byte;

    // Byte currently being shifted out, selected by the byte index
    always_comb begin
        cur_byte = 8'h00;
        case (idx_q)
            2'd0:    cur_byte = {2'b11, 3'b000, hold_q.cmd};
            2'd1:    cur_byte = {2'b00, hold_q.x};
            default: cur_byte = {2'b00, hold_q.y};
        endcase
    end

    assign bit_end = (baud_q == BAUD_LAST);
    assign gap_inc = (gap_q == GAP_LAST) ? gap_q : gap_q + GAP_W'(1);

    // State register and all registered outputs
    always_ff @(posedge clk or negedge reset_btn) begin
        if (!reset_btn) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            bit_q      <= 3'd0;
            baud_q     <= '0;
            gap_q      <= '0;
            tail_q     <= 1'b0;
            hold_q     <= '0;
            tx_pin     <= 1'b1;
            ready      <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            bit_q      <= bit_d;
            baud_q     <= baud_d;
            gap_q      <= gap_d;
            tail_q     <= tail_d;
            hold_q     <= hold_d;
            tx_pin     <= tx_d;
            ready      <= ready_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

    // Next-state and output logic.
    // tx_pin is registered from the current state, so the line trails the FSM
    // by one clock. That trail gives the one-clock start-bit latency. To make
    // up for it, the final stop bit holds STOP for one extra clock (tail_q),
    // which lets the last line bit complete before frame_done and ready rise.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        baud_d  = bit_end ? '0 : baud_q + BAUD_W'(1);
        gap_d   = gap_q;
        tail_d  = tail_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (valid_in && ready) begin
                    hold_d.cmd = cmd_in;
                    hold_d.x   = x_in;
                    hold_d.y   = y_in;
                    idx_d      = 2'd0;
                    bit_d      = 3'd0;
                    state_d    = S_START;
                end
            end

            S_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                tx_d = cur_byte[bit_q];
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end

            S_STOP: begin
                tx_d = 1'b1;
                if (tail_q) begin
                    tail_d  = 1'b0;
                    baud_d  = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    if (idx_q == LAST_IDX) begin
                        tail_d = 1'b1;
                    end else if (GAP_BITS > 0) begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_START;
                    end
                end
            end

            S_GAP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    // Counts completed gap bit-times and stays at GAP_BITS once reached
                    gap_d = gap_inc;
                    if (gap_inc == GAP_LAST) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_START;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = ~ready_d;
    end

endmodule

// File: doc/hid_packet_tx.md
Name: hid_packet_tx

Overview:
- UART-side packet encoder/transmitter for the retro_paint HID link; it is the transmit-side counterpart of the top_fpga receive path.
- Accepts one command {cmd, x, y} per handshake.
- Encodes it as the 3-byte frame Header, X, Y.
- Serializes the frame 8N1, LSB first, on tx_pin.
- Used for loopback self-test of top_fpga and for echoing cursor/draw events to a host.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- GAP_BITS, 0, idle (mark) bit-times inserted between bytes of a frame; no gap after the Y byte.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_btn  input  1  asynchronous, active-low reset.
- cmd_in  input  3  command code (1 = move, 2 = draw; other codes are passed through unchanged).
- x_in  input  6  X coordinate, 0..63.
- y_in  input  6  Y coordinate, 0..63.
- valid_in  input  1  request to send; sampled only while ready=1.
- ready  output  1  high when idle and able to accept a command.
- tx_pin  output  1  serial line; idle high.
- busy  output  1  high while a frame is in flight (equals ~ready).
- frame_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Bit timing: CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer truncation (5208 at the defaults). Every serial bit, including gap bits, lasts exactly CLKS_PER_BIT clocks.
- Byte encoding:
  - Header = {2'b11, 3'b000, cmd_in}; reserved bits [5:3] are always 0.
  - X = {2'b00, x_in}.
  - Y = {2'b00, y_in}.
  - Example: cmd=1 gives header 0xC1.
- Capture: when valid_in && ready on a clock edge, cmd/x/y are registered into the holding register. ready drops in the same edge. The inputs may change freely afterwards.
- No queue: valid_in while ready=0 is ignored and that command is lost.
- FSM states: IDLE, START, DATA, STOP, GAP. A byte index 0..2 tracks the current byte.
  - IDLE: tx_pin=1, ready=1. On capture, go to START with index=0.
  - START: tx_pin=0 for one bit-time, then DATA.
  - DATA: drives bits 0..7 of the current byte, LSB first, one bit-time each, under a 3-bit bit counter. Then STOP.
  - STOP: tx_pin=1 for one bit-time. Then:
    - if index<2 and GAP_BITS>0, go to GAP;
    - if index<2 and GAP_BITS=0, go to START with index+1;
    - if index=2, go to IDLE.
  - GAP: tx_pin=1 for GAP_BITS bit-times, then START with index+1.
- tx_pin is driven from a register. The start bit's falling edge appears on the first edge after the capture edge (latency 1 clock).
- Frame length from the capture edge to frame_done is (30 + 2*GAP_BITS)*CLKS_PER_BIT + 1 clocks.
- frame_done: pulses for one cycle on the edge where STOP of byte 2 expires and the FSM returns to IDLE. ready=1 in that same cycle.
- Back-to-back: valid_in asserted in the frame_done cycle is accepted. The next start bit follows after one clock, with no extra idle time.
- Counters: the baud counter is ceil(log2(CLKS_PER_BIT)) bits wide and reloads at every bit boundary. The gap counter saturates at GAP_BITS.
- Reset values (asynchronous, while reset_btn=0): tx_pin=1, state=IDLE, ready=1, busy=0, frame_done=0, counters=0, holding register=0.
- Reset mid-frame: tx_pin returns to 1 immediately (asynchronously). The partial frame is discarded with no frame_done. After release, the block starts in IDLE.
- valid_in during reset is ignored.

Test Plan:
- Bench parameters: CLK_FREQ=50_000_000, BAUD_RATE=5_000_000 (CLKS_PER_BIT=10), GAP_BITS=0, unless noted. Decode tx_pin with a bench UART monitor.
- Move frame: cmd=1, x=10, y=5, one-cycle valid -> bytes 0xC1, 0x0A, 0x05. frame_done exactly 301 clocks after the capture edge. ready low throughout.
- Draw frame at max coordinates: cmd=2, x=63, y=63 -> 0xC2, 0x3F, 0x3F. Reserved header bits [5:3]=0. Each bit low/high period is exactly 10 clocks.
- Ignored request: a second valid (cmd=1, x=1, y=1) 50 clocks into the frame -> only one frame is observed, with unchanged payload. Changing x_in/y_in after capture has no effect.
- Back-to-back with gap: GAP_BITS=2; valid held high with cmd=1/x=3/y=4, then cmd=2/x=7/y=8 -> two frames. A 20-clock mark gap between bytes. The second start bit is 1 clock after the first frame_done. Each frame_done is 341 clocks after its capture.
- Mid-frame reset: assert reset_btn=0 during DATA of the X byte -> tx_pin=1 in the same timestep, ready=1, no frame_done. After release, a new cmd=2/x=0/y=0 -> 0xC2, 0x00, 0x00 intact.
- Loopback: at the defaults, tx_pin is wired to top_fpga rx_pin; send cmd=1/x=10/y=5 -> top_fpga asserts valid_pulse with cmd_to_screen=1, x_to_screen=10, y_to_screen=5.
